fiber_mem_port_arbiter: RTL

//  Shares one single-port SRAM (sram_sp, 1-cycle read latency) between a write requester (write scanner/buffet

---
 rtl/fiber_mem_port_arbiter_if.sv | 44 ++++
 rtl/fiber_mem_port_arbiter.sv | 131 +++++++++++++
 2 files changed

// File: rtl/fiber_mem_port_arbiter_if.sv
// rtl/fiber_mem_port_arbiter_if.sv - requester, response and SRAM bus bundle for the fiber memory port arbiter
interface fiber_mem_port_arbiter_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 9
);
  logic                  wr_req_valid;
  logic                  wr_req_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  logic                  rd_req_valid;
  logic                  rd_req_ready;
  logic [ADDR_WIDTH-1:0] rd_addr;

  logic [DATA_WIDTH-1:0] rd_resp_data;
  logic                  rd_resp_valid;
  logic                  rd_resp_ready;

  logic [ADDR_WIDTH-1:0] addr_to_mem;
  logic [DATA_WIDTH-1:0] data_to_mem;
  logic                  wen_to_mem;
  logic                  ren_to_mem;
  logic [DATA_WIDTH-1:0] data_from_mem;

  // Arbiter side
  modport slave (
    input  wr_req_valid, wr_addr, wr_data,
    input  rd_req_valid, rd_addr, rd_resp_ready,
    input  data_from_mem,
    output wr_req_ready, rd_req_ready,
    output rd_resp_data, rd_resp_valid,
    output addr_to_mem, data_to_mem, wen_to_mem, ren_to_mem
  );

  // Requester / memory side
  modport master (
    output wr_req_valid, wr_addr, wr_data,
    output rd_req_valid, rd_addr, rd_resp_ready,
    output data_from_mem,
    input  wr_req_ready, rd_req_ready,
    input  rd_resp_data, rd_resp_valid,
    input  addr_to_mem, data_to_mem, wen_to_mem, ren_to_mem
  );
endinterface

// File: rtl/fiber_mem_port_arbiter.sv
// rtl/fiber_mem_port_arbiter.sv - round-robin single-port SRAM arbiter with 2-entry credited read response FIFO
module fiber_mem_port_arbiter #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 9,
  parameter bit WR_FIRST   = 1'b1
) (
  input logic                   clk,
  input logic                   rst,
  input logic                   clk_en,
  input logic                   flush,
  fiber_mem_port_arbiter_if.slave bus
);

  typedef enum logic {
    GRANT_WR = 1'b0,
    GRANT_RD = 1'b1
  } grant_e;

  // The requester that did NOT win last is the one that gets the first tie.
  localparam grant_e RESET_GRANT = WR_FIRST ? GRANT_RD : GRANT_WR;

  grant_e                last_grant_q, last_grant_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            count_q, count_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [DATA_WIDTH-1:0] fifo_q [2];
  logic [DATA_WIDTH-1:0] fifo_d [2];

  logic       clear;
  logic       active;
  logic       resp_valid;
  logic       pop;
  logic       push;
  logic [2:0] credits;
  logic       rd_elig;
  logic       wr_elig;
  logic       grant_wr;
  logic       grant_rd;

  // Eligibility and round-robin grant; a read is only eligible if its response has a guaranteed FIFO slot.
  always_comb begin
    clear      = rst | flush;
    active     = clk_en & ~clear;
    resp_valid = active & (count_q != 2'd0);
    pop        = resp_valid & bus.rd_resp_ready;
    credits    = {1'b0, count_q} + {2'b00, inflight_q};
    rd_elig    = active & bus.rd_req_valid & ((credits - {2'b00, pop}) < 3'd2);
    wr_elig    = active & bus.wr_req_valid;
    grant_wr   = 1'b0;
    grant_rd   = 1'b0;
    if (wr_elig && rd_elig) begin
      if (last_grant_q == GRANT_WR) begin
        grant_rd = 1'b1;
      end else begin
        grant_wr = 1'b1;
      end
    end else begin
      grant_wr = wr_elig;
      grant_rd = rd_elig;
    end
  end

  assign bus.wr_req_ready  = grant_wr;
  assign bus.rd_req_ready  = grant_rd;
  assign bus.wen_to_mem    = grant_wr;
  assign bus.ren_to_mem    = grant_rd;
  assign bus.addr_to_mem   = grant_wr ? bus.wr_addr : (grant_rd ? bus.rd_addr : '0);
  assign bus.data_to_mem   = grant_wr ? bus.wr_data : '0;
  assign bus.rd_resp_valid = resp_valid;
  assign bus.rd_resp_data  = clear ? '0 : fifo_q[rd_ptr_q];

  // Next state: capture the in-flight read, retire popped responses, remember the winner.
  always_comb begin
    last_grant_d = last_grant_q;
    inflight_d   = inflight_q;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    fifo_d       = fifo_q;
    push         = active & inflight_q;
    if (clear) begin
      last_grant_d = RESET_GRANT;
      inflight_d   = 1'b0;
      count_d      = 2'd0;
      rd_ptr_d     = 1'b0;
      wr_ptr_d     = 1'b0;
      fifo_d[0]    = '0;
      fifo_d[1]    = '0;
    end else if (active) begin
      if (grant_wr) begin
        last_grant_d = GRANT_WR;
      end else if (grant_rd) begin
        last_grant_d = GRANT_RD;
      end
      inflight_d = grant_rd;
      if (push) begin
        fifo_d[wr_ptr_q] = bus.data_from_mem;
        wr_ptr_d         = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  // State register with synchronous reset; clk_en gating is folded into the _d logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= RESET_GRANT;
      inflight_q   <= 1'b0;
      count_q      <= 2'd0;
      rd_ptr_q     <= 1'b0;
      wr_ptr_q     <= 1'b0;
      fifo_q       <= '{default: '0};
    end else begin
      last_grant_q <= last_grant_d;
      inflight_q   <= inflight_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      fifo_q       <= fifo_d;
    end
  end

endmodule
